// File: rtl/sram_cache_controller_if.sv
// Bus bundle between the memory stage, the data cache and SRAM_Controller.
interface sram_cache_controller_if;
  // Upstream (memory stage) side
  logic        read_en;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  // Downstream (SRAM_Controller) side
  logic        sram_read_en;
  logic        sram_write_en;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;
  logic        sram_ready;

  // Cache view of the bus
  modport slave (
    input  read_en, write_en, address, write_data, sram_read_data, sram_ready,
    output read_data, ready, sram_read_en, sram_write_en, sram_address, sram_write_data
  );

  // Memory stage plus SRAM_Controller view of the bus
  modport master (
    output read_en, write_en, address, write_data, sram_read_data, sram_ready,
    input  read_data, ready, sram_read_en, sram_write_en, sram_address, sram_write_data
  );
endinterface

// File: rtl/sram_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of SRAM_Controller.
// Lines are two 32-bit words; a miss fills both words with two SRAM reads.
module sram_cache_controller #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_cache_controller_if.slave bus
);

  localparam int unsigned TAG_BITS = 32 - 3 - INDEX_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StFill0, StFill1, StWrite} state_e;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q   [LINES];
  logic [31:0]           word0_q [LINES];
  logic [31:0]           word1_q [LINES];
  logic [31:0]           fill_buf_q, fill_buf_d;

  logic                  word_sel;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  tag_match;
  logic                  hit;
  logic                  line_fill;
  logic                  word_update;

  assign word_sel  = bus.address[2];
  assign index     = bus.address[INDEX_BITS+2:3];
  assign tag       = bus.address[31:INDEX_BITS+3];
  assign tag_match = valid_q[index] && (tag_q[index] == tag);
  assign hit       = bus.read_en && tag_match;

  assign bus.read_data       = word_sel ? word1_q[index] : word0_q[index];
  assign bus.sram_write_data = bus.write_data;

  // Next-state, SRAM sequencing and upstream handshake
  always_comb begin
    state_d           = state_q;
    fill_buf_d        = fill_buf_q;
    bus.ready         = 1'b0;
    bus.sram_read_en  = 1'b0;
    bus.sram_write_en = 1'b0;
    bus.sram_address  = bus.address;
    line_fill         = 1'b0;
    word_update       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Write wins if both enables are (illegally) high together
        if (bus.write_en) begin
          state_d = StWrite;
        end else if (bus.read_en && !hit) begin
          state_d = StFill0;
        end else begin
          bus.ready = 1'b1;
        end
      end
      StFill0: begin
        bus.sram_read_en = 1'b1;
        bus.sram_address = {bus.address[31:3], 3'b000};
        if (bus.sram_ready) begin
          fill_buf_d = bus.sram_read_data;
          state_d    = StFill1;
        end
      end
      StFill1: begin
        bus.sram_read_en = 1'b1;
        bus.sram_address = {bus.address[31:3], 3'b100};
        if (bus.sram_ready) begin
          line_fill = 1'b1;
          state_d   = StIdle;
        end
      end
      StWrite: begin
        bus.sram_write_en = 1'b1;
        if (bus.sram_ready) begin
          bus.ready   = 1'b1;
          word_update = tag_match;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, valid bits and fill buffer; these are the only reset state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fill_buf_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      fill_buf_q <= fill_buf_d;
      if (line_fill) begin
        valid_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (line_fill) begin
      tag_q[index]   <= tag;
      word0_q[index] <= fill_buf_q;
      word1_q[index] <= bus.sram_read_data;
    end else if (word_update) begin
      if (word_sel) begin
        word1_q[index] <= bus.write_data;
      end else begin
        word0_q[index] <= bus.write_data;
      end
    end
  end

endmodule
